// File: rtl/lfsr_seed_sequencer_pkg.sv
// Shared constants, tap positions, state encoding and word payload for the LFSR seed sequencer.
// The tap positions must match the downstream LFSR/mask stage exactly.
package lfsr_seed_sequencer_pkg;

    localparam int unsigned RNDSIZE = 13;
    localparam int unsigned W       = RNDSIZE * (RNDSIZE - 1) / 2;
    localparam int unsigned STEP_W  = 8;
    localparam int unsigned OCNT_W  = 16;
    localparam int unsigned PROB_W  = 2;

    localparam int unsigned TAP_HI = W - 1;
    localparam int unsigned TAP_A  = 3;
    localparam int unsigned TAP_B  = 2;
    localparam int unsigned TAP_C  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0]      seed;
        logic [PROB_W-1:0] prob;
    } word_t;

endpackage

// File: rtl/lfsr_seed_sequencer_lfsr_step.sv
// Combinational single-step LFSR advance: shift left, feedback into bit 0.
module lfsr_seed_sequencer_lfsr_step
    import lfsr_seed_sequencer_pkg::*;
(
    input  logic [W-1:0] state,
    output logic [W-1:0] next_c
);

    logic fb_c;

    assign fb_c   = state[TAP_HI] ^ state[TAP_A] ^ state[TAP_B] ^ state[TAP_C];
    assign next_c = {state[W-2:0], fb_c};

endmodule

// File: rtl/lfsr_seed_sequencer.sv
// Seed source for the LFSR/mask stage: loads a seed, warms up N steps, then streams
// successive LFSR states over a valid/ready handshake.
module lfsr_seed_sequencer
    import lfsr_seed_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [W-1:0]      load_seed,
    input  logic [PROB_W-1:0] load_prob,
    input  logic [STEP_W-1:0] step_count,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_seed,
    output logic [PROB_W-1:0] out_prob,
    output logic [OCNT_W-1:0] out_cnt,
    output logic              busy,
    output logic              seed_err
);

    state_t            state_q;
    state_t            state_d;
    word_t             word_q;
    word_t             word_d;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] steps_d;
    logic [OCNT_W-1:0] cnt_d;
    logic [W-1:0]      step_c;
    logic              valid_d;
    logic              ready_d;
    logic              busy_d;
    logic              err_d;
    logic              xfer_c;

    // Single advance function shared by warm-up and streaming
    lfsr_seed_sequencer_lfsr_step u_step (
        .state  (word_q.seed),
        .next_c (step_c)
    );

    assign xfer_c   = out_valid && out_ready;
    assign out_seed = word_q.seed;
    assign out_prob = word_q.prob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        steps_d = steps_q;
        cnt_d   = out_cnt;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid && load_ready) begin
                    if (load_seed != '0) begin
                        word_d.seed = load_seed;
                        word_d.prob = load_prob;
                        steps_d     = step_count;
                        cnt_d       = '0;
                        state_d     = (step_count != '0) ? ST_RUN : ST_HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    word_d.seed = step_c;
                    steps_d     = steps_q - STEP_W'(1);
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Flush wins over a simultaneous transfer: no step, no count
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (xfer_c) begin
                    word_d.seed = step_c;
                    if (out_cnt != {OCNT_W{1'b1}}) begin
                        cnt_d = out_cnt + OCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Valid trails HOLD entry by one cycle so the first word follows the last warm-up step
        valid_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            steps_q    <= '0;
            out_cnt    <= '0;
            out_valid  <= 1'b0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            seed_err   <= 1'b0;
        end else begin
            word_q     <= word_d;
            steps_q    <= steps_d;
            out_cnt    <= cnt_d;
            out_valid  <= valid_d;
            load_ready <= ready_d;
            busy       <= busy_d;
            seed_err   <= err_d;
        end
    end

endmodule
